// File: rtl/mmm_pkg.sv
// Shared core-wide widths and the BTB entry layout.
package mmm_pkg;

   localparam int XLEN         = 32;
   localparam int OFFSET       = 2;
   localparam int BTB_SET_BITS = 4;
   localparam int BTB_WAYS     = 4;
   localparam int BTB_TAG_W    = XLEN - BTB_SET_BITS - OFFSET;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [XLEN-1:0]      target;
   } btb_entry_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-lookup / branch-resolution bundle for the BTB.
interface btb_assoc_if #(
   parameter int XLEN = mmm_pkg::XLEN
);
   logic            flush;
   logic            lookup;
   logic [XLEN-1:0] pc;
   logic            valid;
   logic            del_entry;
   logic [XLEN-1:0] update_pc;
   logic [XLEN-1:0] target;
   logic            hit;
   logic [XLEN-1:0] pred_target;
   logic            busy;

   modport master (
      output flush, lookup, pc, valid, del_entry, update_pc, target,
      input  hit, pred_target, busy
   );

   modport slave (
      input  flush, lookup, pc, valid, del_entry, update_pc, target,
      output hit, pred_target, busy
   );
endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: heap-ordered node bits, 1 = LRU side is the right child.
module plru_tree #(
   parameter  int WAYS = 4,
   localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1,
   localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [PW-1:0] state,
   input  logic [WB-1:0] touch_way,
   output logic [WB-1:0] victim,
   output logic [PW-1:0] next_state
);

   generate
      if (WAYS == 1) begin : g_single
         assign victim     = '0;
         assign next_state = state;
      end else begin : g_tree
         localparam int LEVELS = $clog2(WAYS);

         always_comb begin
            int node;
            node   = 1;
            victim = '0;
            for (int l = 0; l < LEVELS; l++) begin
               victim[LEVELS-1-l] = state[node-1];
               node = 2 * node + int'(state[node-1]);
            end
         end

         // Touching a way points every node on its path away from it.
         always_comb begin
            int   node;
            logic dir;
            node       = 1;
            next_state = state;
            for (int l = 0; l < LEVELS; l++) begin
               dir                = touch_way[LEVELS-1-l];
               next_state[node-1] = ~dir;
               node = 2 * node + int'(dir);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with tree-PLRU replacement and a set-by-set flush walk.
//  state   | meaning
//  S_IDLE  | normal lookup and update
//  S_FLUSH | clearing set[cnt_q] each cycle; lookups miss, updates dropped
module btb_assoc #(
   parameter int XLEN     = mmm_pkg::XLEN,
   parameter int SET_BITS = mmm_pkg::BTB_SET_BITS,
   parameter int WAYS     = mmm_pkg::BTB_WAYS,
   parameter int OFFSET   = mmm_pkg::OFFSET
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            lookup_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            valid_i,
   input  logic            del_entry_i,
   input  logic [XLEN-1:0] update_pc_i,
   input  logic [XLEN-1:0] target_i,
   output logic            hit_o,
   output logic [XLEN-1:0] pred_target_o,
   output logic            busy_o
);

   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = XLEN - SET_BITS - OFFSET;
   localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;
   localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [0:0]          state_q;
   logic [SET_BITS-1:0] cnt_q;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [PW-1:0]       plru_q  [SETS];
   logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
   logic [XLEN-1:0]     tgt_q   [SETS][WAYS];

   logic                idle;
   logic [SET_BITS-1:0] lk_set, wr_set;
   logic [TAG_W-1:0]    lk_tag, wr_tag;
   logic [WAYS-1:0]     lk_match, wr_match;
   logic [WB-1:0]       lk_way, wr_hit_way, free_way, victim, wr_way;
   logic                wr_hit, wr_full, lk_touch, wr_en, del_en;
   logic [PW-1:0]       lk_next, wr_base, wr_next;

   assign idle   = (state_q == S_IDLE);
   assign busy_o = ~idle;

   assign lk_set = pc_i[SET_BITS+OFFSET-1:OFFSET];
   assign lk_tag = pc_i[XLEN-1:SET_BITS+OFFSET];
   assign wr_set = update_pc_i[SET_BITS+OFFSET-1:OFFSET];
   assign wr_tag = update_pc_i[XLEN-1:SET_BITS+OFFSET];

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         lk_match[w] = idle && valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag);
         wr_match[w] = valid_q[wr_set][w] && (tag_q[wr_set][w] == wr_tag);
      end
   end

   always_comb begin
      lk_way     = '0;
      wr_hit_way = '0;
      free_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (lk_match[w])          lk_way     = WB'(w);
         if (wr_match[w])          wr_hit_way = WB'(w);
         if (!valid_q[wr_set][w])  free_way   = WB'(w);
      end
   end

   always_comb begin
      pred_target_o = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_match[w]) pred_target_o = pred_target_o | tgt_q[lk_set][w];
      end
   end

   assign hit_o    = |lk_match;
   assign wr_hit   = |wr_match;
   assign wr_full  = &valid_q[wr_set];
   assign lk_touch = lookup_i & hit_o;
   assign wr_en    = idle & valid_i & ~del_entry_i;
   assign del_en   = idle & valid_i & del_entry_i & wr_hit;

   // The write's touch is layered on top of a same-set lookup touch so it lands last.
   assign wr_base = (lk_touch && (lk_set == wr_set)) ? lk_next : plru_q[wr_set];
   assign wr_way  = wr_hit ? wr_hit_way : (wr_full ? victim : free_way);

   plru_tree #(.WAYS(WAYS)) u_lk_plru (
      .state      (plru_q[lk_set]),
      .touch_way  (lk_way),
      .victim     (),
      .next_state (lk_next)
   );

   plru_tree #(.WAYS(WAYS)) u_wr_plru (
      .state      (wr_base),
      .touch_way  (wr_way),
      .victim     (victim),
      .next_state (wr_next)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (lk_touch) plru_q[lk_set] <= lk_next;
               if (wr_en) begin
                  valid_q[wr_set][wr_way] <= 1'b1;
                  plru_q[wr_set]          <= wr_next;
               end
               if (del_en) valid_q[wr_set][wr_hit_way] <= 1'b0;
               if (flush_i) begin
                  state_q <= S_FLUSH;
                  cnt_q   <= '0;
               end
            end
            default: begin
               valid_q[cnt_q] <= '0;
               plru_q[cnt_q]  <= '0;
               cnt_q          <= cnt_q + 1'b1;
               if (&cnt_q) state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Tag/target payload is qualified by valid bits, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_q[wr_set][wr_way] <= wr_tag;
         tgt_q[wr_set][wr_way] <= target_i;
      end
   end

endmodule
